// File: rtl/seg_pair_checker_if.sv
// Seven-segment pair bus: raw High/Low segment patterns in, decoded digits and status out.
// Latency: none (wires only).
// Backpressure: none; the segment source free-runs and the checker only observes.
interface seg_pair_checker_if;
    logic [6:0] high;       // tens-digit segments, bit6=a .. bit0=g
    logic [6:0] low;        // units-digit segments, same encoding
    logic [3:0] digit_h;    // last accepted tens digit
    logic [3:0] digit_l;    // last accepted units digit
    logic       valid;      // digits hold a legal accepted value
    logic       step_ok;    // 1-cycle pulse: legal +1 step accepted
    logic       step_err;   // 1-cycle pulse: illegal pattern or illegal step
    logic       locked;     // checker is tracking a clean count
    logic [7:0] err_cnt;    // saturating error count

    // Segment source side (display path or bench)
    modport master (
        output high, low,
        input  digit_h, digit_l, valid, step_ok, step_err, locked, err_cnt
    );

    // Checker side
    modport slave (
        input  high, low,
        output digit_h, digit_l, valid, step_ok, step_err, locked, err_cnt
    );
endinterface

// File: rtl/seg_pair_checker.sv
// Receive-side checker for a 00..59 seven-segment seconds display: deglitch, decode, verify +1 steps.
// Latency: a change held steady updates digits/pulses on the (STABLE_CYCLES+1)-th rising edge after it.
// Backpressure: none; observe-only. SEG_ACTIVE_LOW_EN inverts the segment inputs for common-anode boards.
module seg_pair_checker #(
    parameter int STABLE_CYCLES = 4,    // 2..255 identical samples before a pattern is accepted
    parameter int MAX_H         = 5,    // largest legal tens digit
    parameter int MAX_L         = 9     // largest legal units digit
) (
    input  logic               i_clk,
    input  logic               i_rst,
    seg_pair_checker_if.slave  io_seg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SYNC  = 2'b01,
        ST_TRACK = 2'b10
    } state_t;

    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] STAB_HIT = 8'(STABLE_CYCLES - 1);
    localparam logic [3:0] LIM_H    = 4'(MAX_H);
    localparam logic [3:0] LIM_L    = 4'(MAX_L);

    // Map a segment pattern back to {legal, bcd}; anything outside 0..9 is illegal.
    function automatic logic [4:0] seg_dec(input logic [6:0] s);
        logic [4:0] d;
        case (s)
            7'h7E:   d = 5'h10;
            7'h30:   d = 5'h11;
            7'h6D:   d = 5'h12;
            7'h79:   d = 5'h13;
            7'h33:   d = 5'h14;
            7'h5B:   d = 5'h15;
            7'h5F:   d = 5'h16;
            7'h70:   d = 5'h17;
            7'h7F:   d = 5'h18;
            7'h73:   d = 5'h19;
            default: d = 5'h00;
        endcase
        return d;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [13:0] r_smp;
    logic [7:0]  r_stab_cnt;
    logic [3:0]  r_digit_h;
    logic [3:0]  r_digit_l;
    logic        r_valid;
    logic        r_step_ok;
    logic        r_step_err;
    logic [7:0]  r_err_cnt;

    logic [13:0] w_in;
    logic        w_same;
    logic        w_accept;
    logic [4:0]  w_dec_h;
    logic [4:0]  w_dec_l;
    logic        w_legal;
    logic [3:0]  w_inc_h;
    logic [3:0]  w_inc_l;
    logic        w_is_next;
    logic        w_is_same;
    logic        w_load;
    logic        w_ok;
    logic        w_err;
    logic        w_set_valid;
    logic        w_clr_valid;

`ifdef SEG_ACTIVE_LOW_EN
    assign w_in = ~{io_seg.high, io_seg.low};
`else
    assign w_in = {io_seg.high, io_seg.low};
`endif

    // The incoming sample becomes smp and the current smp becomes prev_smp on the
    // same edge, so comparing them here gives the post-edge smp==prev_smp relation.
    // That lets stab_cnt and the accept event land on the same edge as the sample.
    assign w_same   = (w_in == r_smp);
    assign w_accept = w_same && (r_stab_cnt == STAB_HIT);

    assign w_dec_h  = seg_dec(w_in[13:7]);
    assign w_dec_l  = seg_dec(w_in[6:0]);
    assign w_legal  = w_dec_h[4] && w_dec_l[4] &&
                      (w_dec_h[3:0] <= LIM_H) && (w_dec_l[3:0] <= LIM_L);

    // Expected successor of the held value, wrapping MAX_H/MAX_L back to 00.
    assign w_inc_l   = (r_digit_l == LIM_L) ? 4'd0 : r_digit_l + 4'd1;
    assign w_inc_h   = (r_digit_l != LIM_L) ? r_digit_h :
                       (r_digit_h == LIM_H) ? 4'd0 : r_digit_h + 4'd1;
    assign w_is_next = (w_dec_h[3:0] == w_inc_h) && (w_dec_l[3:0] == w_inc_l);
    assign w_is_same = (w_dec_h[3:0] == r_digit_h) && (w_dec_l[3:0] == r_digit_l);

    // Input register and stability counter (saturates so each run accepts once).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_smp      <= '0;
            r_stab_cnt <= '0;
        end else begin
            r_smp <= w_in;
            if (!w_same)
                r_stab_cnt <= '0;
            else if (r_stab_cnt != STAB_MAX)
                r_stab_cnt <= r_stab_cnt + 8'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state and datapath controls, evaluated only on accept events.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        w_set_valid = 1'b0;
        w_clr_valid = 1'b0;
        case (r_state)
            ST_IDLE, ST_SYNC, ST_TRACK: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_err       = 1'b1;
                        w_clr_valid = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (r_state == ST_IDLE) begin
                        w_load      = 1'b1;
                        w_set_valid = 1'b1;
                        w_state_nxt = ST_SYNC;
                    end else if (w_is_next) begin
                        w_load      = 1'b1;
                        w_ok        = 1'b1;
                        w_state_nxt = ST_TRACK;
                    end else if (!w_is_same) begin
                        // Jump: adopt as the new baseline and re-sync from it.
                        w_load      = 1'b1;
                        w_err       = 1'b1;
                        w_state_nxt = ST_SYNC;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Digits, valid flag, one-cycle pulses and the saturating error counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_digit_h  <= '0;
            r_digit_l  <= '0;
            r_valid    <= 1'b0;
            r_step_ok  <= 1'b0;
            r_step_err <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_step_ok  <= w_ok;
            r_step_err <= w_err;
            if (w_load) begin
                r_digit_h <= w_dec_h[3:0];
                r_digit_l <= w_dec_l[3:0];
            end
            if (w_set_valid)
                r_valid <= 1'b1;
            else if (w_clr_valid)
                r_valid <= 1'b0;
            if (w_err && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign io_seg.digit_h  = r_digit_h;
    assign io_seg.digit_l  = r_digit_l;
    assign io_seg.valid    = r_valid;
    assign io_seg.step_ok  = r_step_ok;
    assign io_seg.step_err = r_step_err;
    assign io_seg.locked   = (r_state == ST_TRACK);
    assign io_seg.err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_seg_pair_checker.sv
// Directed bench for seg_pair_checker (STABLE_CYCLES=4): reset, full sweep, glitch, jump,
// illegal patterns, mid-filter reset and error-count saturation; builds with or without SEG_ACTIVE_LOW_EN.
module tb_seg_pair_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    // Expected digits currently held, used to check nothing moves before the accept edge.
    int   e_dh = 0;
    int   e_dl = 0;

    seg_pair_checker_if bus ();

    seg_pair_checker #(
        .STABLE_CYCLES (4),
        .MAX_H         (5),
        .MAX_L         (9)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_seg (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0:       return 7'h7E;
            1:       return 7'h30;
            2:       return 7'h6D;
            3:       return 7'h79;
            4:       return 7'h33;
            5:       return 7'h5B;
            6:       return 7'h5F;
            7:       return 7'h70;
            8:       return 7'h7F;
            9:       return 7'h73;
            default: return 7'h00;
        endcase
    endfunction

    task automatic drive(input logic [6:0] hp, input logic [6:0] lp);
`ifdef SEG_ACTIVE_LOW_EN
        bus.high = ~hp;
        bus.low  = ~lp;
`else
        bus.high = hp;
        bus.low  = lp;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int dh, input int dl, input int v,
                           input int ok, input int er, input int lk, input int ec);
        chk({tag, ".dh"},  bus.digit_h,  dh);
        chk({tag, ".dl"},  bus.digit_l,  dl);
        chk({tag, ".vld"}, bus.valid,    v);
        chk({tag, ".ok"},  bus.step_ok,  ok);
        chk({tag, ".err"}, bus.step_err, er);
        chk({tag, ".lck"}, bus.locked,   lk);
        chk({tag, ".ec"},  bus.err_cnt,  ec);
    endtask

    // Drive a new pattern, confirm nothing changes by edge 4, check results at edge 5,
    // then confirm the pulses last one cycle only.
    task automatic apply(input string tag, input logic [6:0] hp, input logic [6:0] lp,
                         input int dh, input int dl, input int v,
                         input int ok, input int er, input int lk, input int ec);
        drive(hp, lp);
        repeat (4) tick();
        chk({tag, ".early_ok"},  bus.step_ok,  0);
        chk({tag, ".early_err"}, bus.step_err, 0);
        chk({tag, ".early_dh"},  bus.digit_h,  e_dh);
        chk({tag, ".early_dl"},  bus.digit_l,  e_dl);
        tick();
        chk_all(tag, dh, dl, v, ok, er, lk, ec);
        tick();
        chk({tag, ".clr"}, {bus.step_ok, bus.step_err}, 0);
        e_dh = dh;
        e_dl = dl;
    endtask

    initial begin
        // 1: reset state, then first legal value loads without a pulse.
        drive(seg(0), seg(0));
        repeat (2) tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        apply("first00", seg(0), seg(0), 0, 0, 1, 0, 0, 0, 0);
        repeat (4) tick();
        chk("hold00.pulse", {bus.step_ok, bus.step_err}, 0);

        // 2: full sweep 01..59 then wrap to 00, every step legal.
        for (int v = 1; v <= 60; v++) begin
            apply($sformatf("sweep%0d", v % 60), seg((v % 60) / 10), seg(v % 10),
                  (v % 60) / 10, v % 10, 1, 1, 0, 1, 0);
        end
        for (int v = 1; v <= 5; v++) begin
            apply($sformatf("to%0d", v), seg(0), seg(v), 0, v, 1, 1, 0, 1, 0);
        end

        // 3: two-cycle glitch to 8 is discarded; returning to 5 is a silent re-accept.
        drive(seg(0), seg(8));
        repeat (2) tick();
        drive(seg(0), seg(5));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("glitch.c%0d", i), {bus.step_ok, bus.step_err}, 0);
        end
        chk_all("glitch.end", 0, 5, 1, 0, 0, 1, 0);

        // Walk to 12; 09->10 changes both digits at once.
        for (int v = 6; v <= 12; v++) begin
            apply($sformatf("walk%0d", v), seg(v / 10), seg(v % 10), v / 10, v % 10, 1, 1, 0, 1, 0);
        end

        // 4: jump 12->15 is an error but becomes the baseline; 16 then locks again.
        apply("jump15", seg(1), seg(5), 1, 5, 1, 0, 1, 0, 1);
        apply("after16", seg(1), seg(6), 1, 6, 1, 1, 0, 1, 1);

        // 5: blank tens digit, recovery from IDLE, then tens digit 6 out of range.
        apply("blankH", 7'h00, seg(6), 1, 6, 0, 0, 1, 0, 2);
        apply("reload30", seg(3), seg(0), 3, 0, 1, 0, 0, 0, 2);
        apply("step31", seg(3), seg(1), 3, 1, 1, 1, 0, 1, 2);
        apply("h6", seg(6), seg(0), 3, 1, 0, 0, 1, 0, 3);
        apply("reload45", seg(4), seg(5), 4, 5, 1, 0, 0, 0, 3);
        apply("letterA", seg(4), 7'h77, 4, 5, 0, 0, 1, 0, 4);

        // 6: reset with the filter part-way through a run (stab_cnt=2).
        drive(seg(4), seg(2));
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk_all("midrst", 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        rst = 1'b0;
        e_dh = 0;
        e_dl = 0;
        apply("postrst", seg(4), seg(2), 4, 2, 1, 0, 0, 0, 0);

        // Error counter saturates at FF after 300 illegal accepts.
        for (int i = 1; i <= 300; i++) begin
            apply($sformatf("sat%0d", i), 7'h00, (i % 2 == 1) ? 7'h00 : 7'h01,
                  4, 2, 0, 0, 1, 0, (i > 255) ? 255 : i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
